pipe_hazard_scoreboard: RTL and testbench
=========================================

// Module: pipe_hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding/flush controller for the in-order RISC-V pipeline.
//  - Replaces the fixed load-use detector and 2-stage forwarding unit.
//  - Tracks in-flight register writers in an age-ordered history with per-writer result latency.
//  - Drives ID stall, EX operand bypass selects and the flush of wrong-path history on a branch redirect.
// PARAMETERS
//  REG_AW      5  register index width (rd/rs1/rs2)
//  FWD_STAGES  2  bypass depth = history depth; age k = bypass from stage k (1=EX/MEM, 2=MEM/WB)
//  LAT_W       2  width of issue_lat; legal latency range 1..FWD_STAGES
//  FLUSH_DEPTH 1  youngest history entries invalidated by redirect (range 0..FWD_STAGES)
//  CNT_W       32 perf counter width (SB_PERF_EN only)
// PORTS
//  clk           in  1      clock, rising edge
//  reset         in  1      synchronous, active-high
//  issue_valid   in  1      ID holds a valid instruction
//  issue_rd      in  REG_AW destination register of ID instruction
//  issue_regwr   in  1      ID instruction writes rd
//  issue_lat     in  LAT_W  cycles until result is bypassable (ALU=1, load=2)
//  rs1, rs2      in  REG_AW ID source registers
//  use_rs1/2     in  1      source actually read
//  redirect      in  1      taken branch resolved in MEM
//  stall         out 1      hold PC/IF-ID, inject bubble into ID/EX
//  flush         out 1      = redirect; squashes younger pipeline regs
//  fwd_a, fwd_b  out $clog2(FWD_STAGES+1)  0=regfile, k=bypass from age-k stage
//  stall_cnt     out CNT_W  SB_PERF_EN only
//  flush_cnt     out CNT_W  SB_PERF_EN only
// BEHAVIOUR
//  - State: hist[0..FWD_STAGES-1] of {v, rd, lat}; hist[k] holds the instruction with age k+1.
//  - Reset: all v=0; stall=0, flush=0, fwd_a=fwd_b=0, counters=0. Reset beats redirect.
//  - Each edge: hist shifts by one (hist[k+1]<=hist[k]); the oldest entry falls out (value is in regfile).
//  - New hist[0]:
//    * {1, issue_rd, issue_lat} when accept = issue_valid & ~stall & ~redirect & issue_regwr & issue_rd!=0.
//    * Otherwise v=0 (bubble).
//  - issue_lat=0 is treated as 1; values >FWD_STAGES are clamped to FWD_STAGES.
//  - Source lookup (combinational from registered state, 0-cycle):
//    * Match = youngest valid entry with rd==rs, rs!=0, use_rs=1.
//    * Hazard if match age < lat.
//    * Otherwise fwd = match age, or 0 if there is no match.
//    * Only the youngest match is considered; older matches are shadowed.
//  - stall = issue_valid & (haz_rs1 | haz_rs2) & ~redirect. Flush has priority over stall.
//  - While stall is high, fwd_* remain valid for the held instruction and are re-evaluated every cycle.
//  - redirect edge:
//    * Entries hist[0..FLUSH_DEPTH-1] have v cleared after the shift.
//    * The ID instruction is not recorded.
//    * Older entries survive.
//  - flush = redirect (combinational pass-through; asserted in the same cycle).
//  - Back-to-back stalls: a load (lat 2) followed by a dependent use gives exactly 1 stall cycle,
//    then fwd=2. A lat=FWD_STAGES producer gives FWD_STAGES-1 stall cycles.
// CONFIGURATION
//  SB_PERF_EN defined:
//    * stall_cnt += 1 each cycle stall=1; flush_cnt += 1 each cycle redirect=1.
//    * Both wrap modulo 2^CNT_W and clear on reset.
//  SB_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared package pipe_pkg:
//    * REG_AW, FWD_SEL_REGFILE=0, LAT_ALU=1, LAT_LOAD=2
//    * sb_entry_t {v, rd, lat}
//  - Sub-module sb_src_lookup:
//    * Inputs: history vector, rs, use.
//    * Outputs: hazard, fwd_sel.
//    * Instantiated twice (rs1, rs2).
//  - Top: history shift register, accept/stall/flush logic, perf counters.
// TESTING
//  1. ALU x5 (lat1) issue, next cycle rs1=x5 use -> stall=0, fwd_a=1;
//     following cycle rs1=x5 -> fwd_a=2; then fwd_a=0.
//  2. Load x7 (lat2), next cycle rs2=x7 -> stall=1 one cycle, fwd_b=2 after; bubble in hist[0].
//  3. Both writers of x3 in flight (ages 1 and 2), rs1=x3 -> fwd_a=1 (youngest wins).
//  4. rd=x0 issue, then rs1=x0 use -> no stall, fwd_a=0; issue_regwr=0 never matches.
//  5. Load x9 issued, redirect next cycle with dependent in ID:
//     -> flush=1, stall=0, hist[0] cleared, older entry kept.
//  6. Reset asserted with valid history and redirect -> next cycle all outputs 0;
//     with SB_PERF_EN, 3 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard scoreboard
package pipe_pkg;

    localparam int REG_AW          = 5;
    localparam int LAT_W           = 2;
    localparam int FWD_SEL_REGFILE = 0;
    localparam int LAT_ALU         = 1;
    localparam int LAT_LOAD        = 2;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic [LAT_W-1:0]  lat;
    } sb_entry_t;

endpackage

// File: rtl/sb_src_lookup.sv
// rtl/sb_src_lookup.sv - youngest-writer lookup for one source operand: hazard flag and bypass select
module sb_src_lookup
    import pipe_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
    input  sb_entry_t [FWD_STAGES-1:0] i_hist,
    input  logic [REG_AW-1:0]          i_rs,
    input  logic                       i_use,
    output logic                       o_hazard,
    output logic [FWD_SEL_W-1:0]       o_fwd_sel
);

    logic w_found;
    logic w_hit;
    logic w_haz;
    int   w_age;
    int   w_lat;

    // Scan oldest to youngest so the youngest match overwrites and shadows older ones.
    always_comb begin
        w_found = 1'b0;
        w_age   = 0;
        w_lat   = 0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (i_hist[k].v && (i_hist[k].rd == i_rs)) begin
                w_found = 1'b1;
                w_age   = k + 1;
                w_lat   = int'(i_hist[k].lat);
            end
        end
        w_hit = w_found && i_use && (i_rs != '0);
        w_haz = w_hit && (w_age < w_lat);
    end

    assign o_hazard  = w_haz;
    assign o_fwd_sel = (w_hit && !w_haz) ? FWD_SEL_W'(w_age) : FWD_SEL_W'(FWD_SEL_REGFILE);

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - in-flight writer history, ID stall, EX bypass selects, redirect flush; SB_PERF_EN adds counters
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int FWD_STAGES  = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 32,
    localparam int FWD_SEL_W  = $clog2(FWD_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REG_AW-1:0]    issue_rd,
    input  logic                 issue_regwr,
    input  logic [LAT_W-1:0]     issue_lat,
    input  logic [REG_AW-1:0]    rs1,
    input  logic [REG_AW-1:0]    rs2,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    input  logic                 redirect,
    output logic                 stall,
    output logic                 flush,
    output logic [FWD_SEL_W-1:0] fwd_a,
    output logic [FWD_SEL_W-1:0] fwd_b
`ifdef SB_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    sb_entry_t [FWD_STAGES-1:0] r_hist;
    sb_entry_t [FWD_STAGES-1:0] w_hist_nxt;
    logic                       w_haz_a;
    logic                       w_haz_b;
    logic                       w_stall;
    logic                       w_accept;
    logic [LAT_W-1:0]           w_lat_eff;

    sb_src_lookup #(.FWD_STAGES(FWD_STAGES), .FWD_SEL_W(FWD_SEL_W)) u_lookup_a (
        .i_hist    (r_hist),
        .i_rs      (rs1),
        .i_use     (use_rs1),
        .o_hazard  (w_haz_a),
        .o_fwd_sel (fwd_a)
    );

    sb_src_lookup #(.FWD_STAGES(FWD_STAGES), .FWD_SEL_W(FWD_SEL_W)) u_lookup_b (
        .i_hist    (r_hist),
        .i_rs      (rs2),
        .i_use     (use_rs2),
        .o_hazard  (w_haz_b),
        .o_fwd_sel (fwd_b)
    );

    // A latency of 0 still needs one stage; anything beyond the history depth saturates.
    always_comb begin
        w_lat_eff = issue_lat;
        if (issue_lat == '0) begin
            w_lat_eff = LAT_W'(1);
        end else if (int'(issue_lat) > FWD_STAGES) begin
            w_lat_eff = LAT_W'(FWD_STAGES);
        end
    end

    assign w_stall  = issue_valid && (w_haz_a || w_haz_b) && !redirect;
    assign w_accept = issue_valid && !w_stall && !redirect && issue_regwr && (issue_rd != '0);
    assign stall    = w_stall;
    assign flush    = redirect;

    always_comb begin
        w_hist_nxt = '0;
        if (w_accept) begin
            w_hist_nxt[0] = '{v: 1'b1, rd: issue_rd, lat: w_lat_eff};
        end
        for (int k = 1; k < FWD_STAGES; k++) begin
            w_hist_nxt[k] = r_hist[k-1];
        end
        // Wrong-path writers younger than the branch are squashed after the shift.
        if (redirect) begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                if (k < FLUSH_DEPTH) begin
                    w_hist_nxt[k].v = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
        end else begin
            r_hist <= w_hist_nxt;
        end
    end

`ifdef SB_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (redirect) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed table-driven bench for pipe_hazard_scoreboard
module tb_pipe_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_regwr;
    logic [1:0] issue_lat;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       redirect;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
`ifdef SB_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_regwr (issue_regwr),
        .issue_lat   (issue_lat),
        .rs1         (rs1),
        .rs2         (rs2),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .redirect    (redirect),
        .stall       (stall),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
`ifdef SB_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    typedef struct {
        int v, rd, wr, lat;
        int rs1, u1, rs2, u2, redir;
        int es, ef, ea, eb;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(int v, int rd, int wr, int lat, int r1, int u1, int r2, int u2,
                                int redir, int es, int ef, int ea, int eb);
        vec_t t;
        t.v = v; t.rd = rd; t.wr = wr; t.lat = lat;
        t.rs1 = r1; t.u1 = u1; t.rs2 = r2; t.u2 = u2; t.redir = redir;
        t.es = es; t.ef = ef; t.ea = ea; t.eb = eb;
        return t;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input vec_t t);
        issue_valid = 1'(t.v);
        issue_rd    = 5'(t.rd);
        issue_regwr = 1'(t.wr);
        issue_lat   = 2'(t.lat);
        rs1         = 5'(t.rs1);
        use_rs1     = 1'(t.u1);
        rs2         = 5'(t.rs2);
        use_rs2     = 1'(t.u2);
        redirect    = 1'(t.redir);
    endtask

    // ea/eb < 0: select not checked (operand is in a hazard that cycle).
    task automatic apply(input vec_t t, input int idx);
        drive(t);
        @(negedge clk);
        chk($sformatf("row%0d.stall", idx), stall, t.es);
        chk($sformatf("row%0d.flush", idx), flush, t.ef);
        if (t.ea >= 0) chk($sformatf("row%0d.fwd_a", idx), fwd_a, t.ea);
        if (t.eb >= 0) chk($sformatf("row%0d.fwd_b", idx), fwd_b, t.eb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          v  rd wr lat rs1 u1 rs2 u2 rd | st fl  fa  fb
        vq.push_back(mk(1,  5, 1, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // ALU x5
        vq.push_back(mk(1,  0, 0, 1,  5, 1,  0, 0, 0,  0, 0,  1,  0));
        vq.push_back(mk(1,  0, 0, 1,  5, 1,  0, 0, 0,  0, 0,  2,  0));
        vq.push_back(mk(1,  0, 0, 1,  5, 1,  0, 0, 0,  0, 0,  0,  0));
        vq.push_back(mk(1,  7, 1, 2,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // load x7
        vq.push_back(mk(1,  8, 1, 1,  0, 0,  7, 1, 0,  1, 0,  0, -1));
        vq.push_back(mk(1,  8, 1, 1,  0, 0,  7, 1, 0,  0, 0,  0,  2));
        vq.push_back(mk(1,  0, 0, 1,  8, 1,  7, 1, 0,  0, 0,  1,  0));
        vq.push_back(mk(0,  0, 0, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0));
        vq.push_back(mk(0,  0, 0, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0));
        vq.push_back(mk(1,  3, 1, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // two writers of x3
        vq.push_back(mk(1,  3, 1, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0));
        vq.push_back(mk(1,  0, 0, 1,  3, 1,  3, 1, 0,  0, 0,  1,  1));
        vq.push_back(mk(1,  0, 0, 1,  3, 1,  0, 0, 0,  0, 0,  2,  0));
        vq.push_back(mk(1,  3, 1, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // older ALU x3
        vq.push_back(mk(1,  3, 1, 2,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // younger load x3
        vq.push_back(mk(1,  0, 0, 1,  3, 1,  0, 0, 0,  1, 0, -1,  0));
        vq.push_back(mk(1,  0, 0, 1,  3, 1,  0, 0, 0,  0, 0,  2,  0));
        vq.push_back(mk(1,  0, 1, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // rd = x0
        vq.push_back(mk(1,  0, 0, 1,  0, 1,  0, 1, 0,  0, 0,  0,  0));
        vq.push_back(mk(1,  6, 0, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // regwr = 0
        vq.push_back(mk(1,  0, 0, 1,  6, 1,  0, 0, 0,  0, 0,  0,  0));
        vq.push_back(mk(1, 10, 1, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0));
        vq.push_back(mk(1,  0, 0, 1, 10, 0, 10, 1, 0,  0, 0,  0,  1)); // use_rs1 = 0
        vq.push_back(mk(1, 11, 1, 1,  0, 0,  0, 0, 0,  0, 0,  0,  0));
        vq.push_back(mk(1,  9, 1, 2,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // load x9
        vq.push_back(mk(1,  4, 1, 1,  9, 1,  0, 0, 1,  0, 1, -1,  0)); // redirect
        vq.push_back(mk(1,  0, 0, 1,  9, 1,  4, 1, 0,  0, 0,  2,  0));
        vq.push_back(mk(0,  0, 0, 1,  0, 0,  0, 0, 1,  0, 1,  0,  0));
        vq.push_back(mk(1, 12, 1, 3,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // lat 3 clamps to 2
        vq.push_back(mk(1,  0, 0, 1, 12, 1,  0, 0, 0,  1, 0, -1,  0));
        vq.push_back(mk(1,  0, 0, 1, 12, 1,  0, 0, 0,  0, 0,  2,  0));
        vq.push_back(mk(1, 13, 1, 0,  0, 0,  0, 0, 0,  0, 0,  0,  0)); // lat 0 acts as 1
        vq.push_back(mk(1,  0, 0, 1, 13, 1,  0, 0, 0,  0, 0,  1,  0));

        reset = 1'b1;
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset.stall", stall, 0);
        chk("reset.flush", flush, 0);
        chk("reset.fwd_a", fwd_a, 0);
        chk("reset.fwd_b", fwd_b, 0);
`ifdef SB_PERF_EN
        chk("reset.stall_cnt", stall_cnt, 0);
        chk("reset.flush_cnt", flush_cnt, 0);
`endif
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

`ifdef SB_PERF_EN
        chk("perf.stall_cnt", stall_cnt, 3);
        chk("perf.flush_cnt", flush_cnt, 2);
`endif

        // Reset must win over a concurrent redirect and wipe the surviving older entry.
        apply(mk(1, 14, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 100);
        drive(mk(1, 0, 0, 1, 14, 1, 0, 0, 1, 0, 1, 0, 0));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_redir.flush", flush, 1);
        chk("rst_redir.stall", stall, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        chk("post_rst.stall", stall, 0);
        chk("post_rst.flush", flush, 0);
        chk("post_rst.fwd_a", fwd_a, 0);
        chk("post_rst.fwd_b", fwd_b, 0);
`ifdef SB_PERF_EN
        chk("post_rst.stall_cnt", stall_cnt, 0);
        chk("post_rst.flush_cnt", flush_cnt, 0);
`endif
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
